// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes and control-word fields.
// Build with ILLEGAL_OPCODE_TRAP_EN defined to add the TRAP state for unknown opcodes.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
`ifdef ILLEGAL_OPCODE_TRAP_EN
        ,
        StTrap   = 4'd12
`endif
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       ir_write;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_output_decode.sv
// mc_output_decode: purely combinational state -> control-word decoder (Moore outputs,
// except that FETCH qualifies its writes with mem_ready).
module mc_output_decode
    import multicycle_control_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            StFetch: begin
                ctrl_o.alu_src_b = SrcBFour;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            StDecode: ctrl_o.alu_src_b = SrcBImmSh2;
            StMemAdr: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBImm;
            end
            StMemRd: ctrl_o.iord = 1'b1;
            StMemWb: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            // Held through stalls; memory qualifies the strobe with mem_ready.
            StMemWr: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            StExec: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = AluOpFunct;
            end
            StAluWb: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            StBranch: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = AluOpSub;
                ctrl_o.pc_src    = PcSrcAluOut;
                ctrl_o.branch    = 1'b1;
            end
            StAddiEx: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBImm;
            end
            StAddiWb: ctrl_o.reg_write = 1'b1;
            StJump: begin
                ctrl_o.pc_src   = PcSrcJump;
                ctrl_o.pc_write = 1'b1;
            end
`ifdef ILLEGAL_OPCODE_TRAP_EN
            StTrap: ctrl_o.illegal = 1'b1;
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register and next-state logic.
// Optional ILLEGAL_OPCODE_TRAP_EN sends unknown opcodes to a sticky TRAP state.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               ir_write,
    output logic               mem_write,
    output logic               iord,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [1:0]         alu_op,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
`ifdef ILLEGAL_OPCODE_TRAP_EN
                    default:    state_d = StTrap;
`else
                    default:    state_d = StFetch;
`endif
                endcase
            end
            StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StAluWb, StBranch, StAddiWb, StJump: state_d = StFetch;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            StTrap:   state_d = StTrap;
`endif
            default:  state_d = StFetch;
        endcase
    end

    mc_output_decode u_output_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    // Write strobes are gated by rst_n so nothing commits while reset is held.
    assign pc_en      = rst_n & (ctrl.pc_write | (ctrl.branch & zero));
    assign ir_write   = rst_n & ctrl.ir_write;
    assign mem_write  = rst_n & ctrl.mem_write;
    assign reg_write  = rst_n & ctrl.reg_write;
    assign iord       = ctrl.iord;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign alu_op     = ctrl.alu_op;
    assign illegal    = ctrl.illegal;
    assign state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through the FSM
// and checks states and control outputs against hand-computed values.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ir_write, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic       illegal;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] SFetch = 4'd0, SDecode = 4'd1, SMemAdr = 4'd2, SMemRd = 4'd3;
    localparam logic [3:0] SMemWb = 4'd4, SMemWr = 4'd5, SExec = 4'd6, SAluWb = 4'd7;
    localparam logic [3:0] SBranch = 4'd8, SAddiEx = 4'd9, SAddiWb = 4'd10, SJump = 4'd11;
    localparam logic [3:0] STrap = 4'd12;

    multicycle_control #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .iord       (iord),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
        #1;
        check("reset_state", 32'(state_o), 32'(SFetch));
        check("reset_pc_en", 32'(pc_en), 0);
        check("reset_srcb", 32'(alu_src_b), 32'd1);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        // FETCH stalls while memory is busy
        check("fetch_stall_state", 32'(state_o), 32'(SFetch));
        check("fetch_stall_ir", 32'(ir_write), 0);
        check("fetch_stall_pc", 32'(pc_en), 0);

        // R-type up to EXEC, then reset mid-instruction
        mem_ready = 1'b1; opcode = 6'b000000;
        tick();
        check("r_decode", 32'(state_o), 32'(SDecode));
        check("r_decode_srcb", 32'(alu_src_b), 32'd3);
        tick();
        check("r_exec", 32'(state_o), 32'(SExec));
        check("r_exec_aluop", 32'(alu_op), 32'd2);
        check("r_exec_srca", 32'(alu_src_a), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_state", 32'(state_o), 32'(SFetch));
        check("rst_mid_ir", 32'(ir_write), 0);
        check("rst_mid_pc", 32'(pc_en), 0);
        check("rst_mid_regw", 32'(reg_write), 0);
        #1 rst_n = 1'b1;
        #1;
        check("rel_ir", 32'(ir_write), 1);
        check("rel_pc", 32'(pc_en), 1);

        // Full R-type
        tick(); tick();
        check("r2_exec", 32'(state_o), 32'(SExec));
        tick();
        check("r2_aluwb", 32'(state_o), 32'(SAluWb));
        check("r2_regdst", 32'(reg_dst), 1);
        check("r2_regw", 32'(reg_write), 1);
        tick();
        check("r2_back", 32'(state_o), 32'(SFetch));

        // lw with no stalls
        opcode = 6'b100011;
        check("lw_fetch_regw", 32'(reg_write), 0);
        tick();
        check("lw_decode", 32'(state_o), 32'(SDecode));
        tick();
        check("lw_memadr", 32'(state_o), 32'(SMemAdr));
        check("lw_memadr_srcb", 32'(alu_src_b), 32'd2);
        tick();
        check("lw_memrd", 32'(state_o), 32'(SMemRd));
        check("lw_memrd_iord", 32'(iord), 1);
        check("lw_memrd_regw", 32'(reg_write), 0);
        tick();
        check("lw_memwb", 32'(state_o), 32'(SMemWb));
        check("lw_memwb_regw", 32'(reg_write), 1);
        check("lw_memwb_m2r", 32'(mem_to_reg), 1);
        tick();
        check("lw_back", 32'(state_o), 32'(SFetch));

        // sw with 3 stall cycles in MEMWR
        opcode = 6'b101011;
        tick(); tick();
        check("sw_memadr", 32'(state_o), 32'(SMemAdr));
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("sw_stall_state", 32'(state_o), 32'(SMemWr));
            check("sw_stall_memw", 32'(mem_write), 1);
            check("sw_stall_regw", 32'(reg_write), 0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("sw_last_memw", 32'(mem_write), 1);
        check("sw_last_iord", 32'(iord), 1);
        tick();
        check("sw_back", 32'(state_o), 32'(SFetch));
        check("sw_back_memw", 32'(mem_write), 0);

        // beq taken then not taken
        opcode = 6'b000100;
        tick(); tick();
        zero = 1'b1; #1;
        check("beq_t_state", 32'(state_o), 32'(SBranch));
        check("beq_t_pcen", 32'(pc_en), 1);
        check("beq_t_pcsrc", 32'(pc_src), 32'd1);
        check("beq_t_aluop", 32'(alu_op), 32'd1);
        tick();
        check("beq_t_back", 32'(state_o), 32'(SFetch));
        tick(); tick();
        zero = 1'b0; #1;
        check("beq_nt_state", 32'(state_o), 32'(SBranch));
        check("beq_nt_pcen", 32'(pc_en), 0);
        tick();
        check("beq_nt_back", 32'(state_o), 32'(SFetch));

        // jump
        opcode = 6'b000010;
        tick(); tick();
        check("j_state", 32'(state_o), 32'(SJump));
        check("j_pcen", 32'(pc_en), 1);
        check("j_pcsrc", 32'(pc_src), 32'd2);
        tick();
        check("j_back", 32'(state_o), 32'(SFetch));

        // addi
        opcode = 6'b001000;
        tick(); tick();
        check("addi_ex", 32'(state_o), 32'(SAddiEx));
        check("addi_ex_srcb", 32'(alu_src_b), 32'd2);
        tick();
        check("addi_wb", 32'(state_o), 32'(SAddiWb));
        check("addi_wb_regw", 32'(reg_write), 1);
        check("addi_wb_regdst", 32'(reg_dst), 0);
        tick();
        check("addi_back", 32'(state_o), 32'(SFetch));

        // unknown opcode
        opcode = 6'b111111;
        tick();
        check("ill_decode", 32'(state_o), 32'(SDecode));
        tick();
`ifdef ILLEGAL_OPCODE_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            check("ill_trap_state", 32'(state_o), 32'(STrap));
            check("ill_trap_flag", 32'(illegal), 1);
            check("ill_trap_en", 32'({pc_en, ir_write, mem_write, reg_write}), 0);
            tick();
        end
`else
        check("ill_nop_state", 32'(state_o), 32'(SFetch));
        check("ill_nop_flag", 32'(illegal), 0);
        check("ill_nop_trapcode", 32'(state_o == STrap), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
